// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : RAW-hazard scoreboard and WB-redirect flush sequencer for the
//               five-stage RV32 pipeline. Define HAZ_FORWARD_EN for cores with
//               EX/MEM forwarding (only load-use hazards stall).
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
   parameter int PIPE_DEPTH   = 3,
   parameter int FLUSH_CYCLES = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dec_valid,
   input  logic [4:0]  dec_rs1,
   input  logic [4:0]  dec_rs2,
   input  logic        dec_rs1_used,
   input  logic        dec_rs2_used,
   input  logic [4:0]  dec_rd,
   input  logic        dec_rf_we,
   input  logic        dec_is_load,
   input  logic        wb_pc_src,
   output logic        stall_o,
   output logic        flush_o,
   output logic        busy_o,
   output logic [15:0] stall_count_o
);

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   localparam logic [3:0] c_cnt_reload = 4'(FLUSH_CYCLES - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [3:0]            r_cnt;
   logic [3:0]            w_cnt_nxt;

   logic [PIPE_DEPTH-1:0] r_sb_valid;
   logic [PIPE_DEPTH-1:0] r_sb_load;
   logic [4:0]            r_sb_rd [PIPE_DEPTH];
   logic [15:0]           r_stall_cnt;

   logic [PIPE_DEPTH-1:0] w_rs1_match;
   logic [PIPE_DEPTH-1:0] w_rs2_match;
   logic                  w_rs1_haz;
   logic                  w_rs2_haz;
   logic                  w_flush;
   logic                  w_stall;
   logic                  w_issue;
   logic                  w_unused;

   // Per-entry match; with forwarding only a load sitting in EX can stall.
   for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_match
`ifdef HAZ_FORWARD_EN
      if (gi == 0) begin : g_load_use
         assign w_rs1_match[gi] = r_sb_valid[gi] & r_sb_load[gi] & (r_sb_rd[gi] == dec_rs1);
         assign w_rs2_match[gi] = r_sb_valid[gi] & r_sb_load[gi] & (r_sb_rd[gi] == dec_rs2);
      end else begin : g_forwarded
         assign w_rs1_match[gi] = 1'b0;
         assign w_rs2_match[gi] = 1'b0;
      end
`else
      assign w_rs1_match[gi] = r_sb_valid[gi] & (r_sb_rd[gi] == dec_rs1);
      assign w_rs2_match[gi] = r_sb_valid[gi] & (r_sb_rd[gi] == dec_rs2);
`endif
   end

   assign w_rs1_haz = dec_rs1_used & (dec_rs1 != 5'd0) & (|w_rs1_match);
   assign w_rs2_haz = dec_rs2_used & (dec_rs2 != 5'd0) & (|w_rs2_match);

   assign w_flush = ~rst & (wb_pc_src | (r_state == ST_FLUSH));
   assign w_stall = ~rst & dec_valid & (w_rs1_haz | w_rs2_haz) & ~w_flush;
   assign w_issue = dec_valid & dec_rf_we & (dec_rd != 5'd0) & ~w_stall & ~w_flush;

   assign stall_o       = w_stall;
   assign flush_o       = w_flush;
   assign busy_o        = (r_state == ST_FLUSH);
   assign stall_count_o = r_stall_cnt;

   // Tail entry and load flags are only partly consumed depending on the build.
   assign w_unused = ^{r_sb_load, r_sb_valid, r_sb_rd[PIPE_DEPTH-1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_RUN;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_RUN: begin
            if (wb_pc_src) begin
               w_state_nxt = ST_FLUSH;
               w_cnt_nxt   = c_cnt_reload;
            end
         end
         ST_FLUSH: begin
            if (wb_pc_src) begin
               w_cnt_nxt = c_cnt_reload;
            end else if (r_cnt == 4'd0) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         default: begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   // Scoreboard shifts every cycle, even while stalled; a redirect wipes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sb_valid <= '0;
         r_sb_load  <= '0;
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            r_sb_rd[i] <= 5'd0;
         end
      end else begin
         r_sb_valid[0] <= w_issue & ~wb_pc_src;
         r_sb_load[0]  <= dec_is_load;
         r_sb_rd[0]    <= dec_rd;
         for (int i = 1; i < PIPE_DEPTH; i++) begin
            r_sb_valid[i] <= r_sb_valid[i-1] & ~wb_pc_src;
            r_sb_load[i]  <= r_sb_load[i-1];
            r_sb_rd[i]    <= r_sb_rd[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= 16'd0;
      end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl against an issue-history
//               reference model (HAZ_FORWARD_EN selects the forwarding rules).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

   localparam int PIPE_DEPTH   = 3;
   localparam int FLUSH_CYCLES = 3;
`ifdef HAZ_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        dec_valid;
   logic [4:0]  dec_rs1;
   logic [4:0]  dec_rs2;
   logic        dec_rs1_used;
   logic        dec_rs2_used;
   logic [4:0]  dec_rd;
   logic        dec_rf_we;
   logic        dec_is_load;
   logic        wb_pc_src;
   logic        stall_o;
   logic        flush_o;
   logic        busy_o;
   logic [15:0] stall_count_o;

   always #5 clk = ~clk;

   hazard_ctrl #(
      .PIPE_DEPTH   (PIPE_DEPTH),
      .FLUSH_CYCLES (FLUSH_CYCLES)
   ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .dec_valid     (dec_valid),
      .dec_rs1       (dec_rs1),
      .dec_rs2       (dec_rs2),
      .dec_rs1_used  (dec_rs1_used),
      .dec_rs2_used  (dec_rs2_used),
      .dec_rd        (dec_rd),
      .dec_rf_we     (dec_rf_we),
      .dec_is_load   (dec_is_load),
      .wb_pc_src     (wb_pc_src),
      .stall_o       (stall_o),
      .flush_o       (flush_o),
      .busy_o        (busy_o),
      .stall_count_o (stall_count_o)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: list of issued writes tagged with their issue cycle.
   typedef struct {
      int rd;
      bit ld;
      int cyc;
   } wr_t;

   wr_t inflight[$];
   int  cyc_no       = 0;
   int  flush_left   = 0;
   int  model_stalls = 0;

   bit  obs_stall;
   bit  obs_flush;
   bit  obs_busy;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc_no, got, exp);
      end
   endtask

   function automatic bit src_hazard(input int rs, input bit used);
      if (!used || rs == 0) return 1'b0;
      foreach (inflight[k]) begin
         int age;
         age = cyc_no - inflight[k].cyc;
         if (inflight[k].rd == rs) begin
            if (FWD) begin
               if (age == 1 && inflight[k].ld) return 1'b1;
            end else if (age <= PIPE_DEPTH) begin
               return 1'b1;
            end
         end
      end
      return 1'b0;
   endfunction

   // One clock: drive, compare mid-cycle, advance the model at the edge.
   task automatic step(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit we, input bit ld, input bit pc, input bit r);
      bit e_stall;
      bit e_flush;
      bit e_busy;
      rst          = r;
      dec_valid    = v;
      dec_rs1      = 5'(rs1);
      dec_rs1_used = u1;
      dec_rs2      = 5'(rs2);
      dec_rs2_used = u2;
      dec_rd       = 5'(rd);
      dec_rf_we    = we;
      dec_is_load  = ld;
      wb_pc_src    = pc;
      #4;
      e_flush = !r && (pc || flush_left > 0);
      e_stall = !r && v && (src_hazard(rs1, u1) || src_hazard(rs2, u2)) && !e_flush;
      e_busy  = (flush_left > 0);
      obs_stall = stall_o;
      obs_flush = flush_o;
      obs_busy  = busy_o;
      check_value("stall_o", 32'(stall_o), 32'(e_stall));
      check_value("flush_o", 32'(flush_o), 32'(e_flush));
      check_value("busy_o", 32'(busy_o), 32'(e_busy));
      check_value("stall_count_o", 32'(stall_count_o), 32'(model_stalls));
      @(posedge clk);
      if (r) begin
         inflight.delete();
         flush_left   = 0;
         model_stalls = 0;
      end else begin
         if (e_stall && model_stalls < 65535) model_stalls++;
         if (pc) begin
            inflight.delete();
            flush_left = FLUSH_CYCLES;
         end else begin
            if (flush_left > 0) flush_left--;
            if (v && we && rd != 0 && !e_stall && !e_flush)
               inflight.push_back('{rd: rd, ld: ld, cyc: cyc_no});
         end
      end
      cyc_no++;
      while (inflight.size() > 0 && (cyc_no - inflight[0].cyc) > PIPE_DEPTH)
         inflight.delete(0);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Hold a consumer in decode until it issues; returns stall cycles seen.
   task automatic consume(input int rs1, input bit u1, input int rs2, input bit u2,
                          input int rd, output int stalls);
      bit issued;
      issued = 1'b0;
      stalls = 0;
      for (int k = 0; k < 10 && !issued; k++) begin
         step(1, rs1, u1, rs2, u2, rd, 1, 0, 0, 0);
         if (obs_stall) stalls++;
         else issued = 1'b1;
      end
      check_value("consumer_issued", 32'(issued), 32'd1);
   endtask

   // Redirect at k=0 (and again at k=pulse_at if non-zero) with a rs1=5 consumer.
   task automatic redirect_run(input int pulse_at, output int nflush, output int nbusy,
                               output int nstall, output bit last_stall);
      bit done;
      done   = 1'b0;
      nflush = 0;
      nbusy  = 0;
      nstall = 0;
      for (int k = 0; k < 20 && !done; k++) begin
         step(1, 5, 1, 0, 0, 12, 1, 0, (k == 0) || (pulse_at != 0 && k == pulse_at), 0);
         if (obs_flush) begin
            nflush++;
            if (obs_busy) nbusy++;
            if (obs_stall) nstall++;
         end else begin
            done       = 1'b1;
            last_stall = obs_stall;
         end
      end
      check_value("flush_ended", 32'(done), 32'd1);
   endtask

   initial begin
      int  s;
      int  nf;
      int  nb;
      int  ns;
      bit  ls;
      rst = 1'b1; dec_valid = 1'b1; dec_rs1 = '0; dec_rs2 = '0;
      dec_rs1_used = 1'b1; dec_rs2_used = 1'b0; dec_rd = '0;
      dec_rf_we = 1'b0; dec_is_load = 1'b0; wb_pc_src = 1'b0;
      @(posedge clk); #1;

      step(1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
      step(1, 0, 1, 0, 0, 0, 0, 0, 0, 1);

      // RAW on x5
      step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
      consume(5, 1, 0, 0, 6, s);
      check_value("raw_stalls", 32'(s), FWD ? 32'd0 : 32'd3);
      check_value("raw_count", 32'(stall_count_o), FWD ? 32'd0 : 32'd3);
      idle(4);

      // Load-use on x7 through rs2, then non-load producer on x8
      step(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
      consume(0, 0, 7, 1, 9, s);
      check_value("load_use_stalls", 32'(s), FWD ? 32'd1 : 32'd3);
      idle(4);
      step(1, 0, 0, 0, 0, 8, 1, 0, 0, 0);
      consume(8, 1, 0, 0, 10, s);
      check_value("alu_dep_stalls", 32'(s), FWD ? 32'd0 : 32'd3);
      idle(4);

      // x0 producer and unused operand
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      consume(0, 1, 0, 0, 11, s);
      check_value("x0_stalls", 32'(s), 32'd0);
      idle(4);
      step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
      consume(3, 0, 0, 0, 13, s);
      check_value("unused_stalls", 32'(s), 32'd0);
      idle(4);

      // Redirect with a pending x5 hazard
      step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
      redirect_run(0, nf, nb, ns, ls);
      check_value("redir_flush_cycles", 32'(nf), 32'(1 + FLUSH_CYCLES));
      check_value("redir_busy_cycles", 32'(nb), 32'(FLUSH_CYCLES));
      check_value("redir_stall_cycles", 32'(ns), 32'd0);
      check_value("post_flush_stall", 32'(ls), 32'd0);
      idle(4);

      // Second redirect at FLUSH cycle 2
      redirect_run(2, nf, nb, ns, ls);
      check_value("reredir_flush_cycles", 32'(nf), 32'(3 + FLUSH_CYCLES));
      check_value("reredir_busy_cycles", 32'(nb), 32'(2 + FLUSH_CYCLES));
      idle(2);

      // Reset in the middle of FLUSH
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      check_value("rst_flush_forced", 32'(obs_flush), 32'd0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check_value("rst_mid_flush_flush", 32'(obs_flush), 32'd0);
      check_value("rst_mid_flush_busy", 32'(obs_busy), 32'd0);

      // Randomized traffic on a small register window
      for (int n = 0; n < 600; n++) begin
         int r;
         r = int'($urandom_range(0, 199));
         step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
              int'($urandom_range(0, 7)), ($urandom_range(0, 1) != 0), int'($urandom_range(0, 7)),
              ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0), (r < 8), (r == 199));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc_no);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
